fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch stage in front of the ARMv8 core: owns the fetch PC, fetches from a
//  wait-state instruction memory via req/ack, buffers up to DEPTH instructions with their PCs.
//  Core pops instructions in order; branches and jumps flush the queue via a redirect.
// PARAMETERS
//  DEPTH     4    queue entries; power of two, >=2
//  RESET_PC  0    64-bit fetch address after reset
// PORTS
//  i_clk        in   1    clock, rising edge
//  i_rst        in   1    synchronous reset, active high
//  o_memReq     out  1    fetch request to instruction memory
//  o_memAdd     out  64   address of outstanding request
//  i_memAck     in   1    memory accepts request; i_memIns valid this cycle
//  i_memIns     in   32   instruction word
//  o_insValid   out  1    queue head valid
//  o_ins        out  32   head instruction
//  o_insPC      out  64   head instruction address
//  i_insTake    in   1    core pops head
//  i_redirect   in   1    flush queue, restart fetch
//  i_redirectPC in   64   new fetch address; bits [1:0] forced to 0
//  o_count      out  $clog2(DEPTH+1)  entries held
//  o_full       out  1    o_count==DEPTH
//  o_empty      out  1    o_count==0
// BEHAVIOUR
//  Reset: state IDLE, o_memReq=0, o_memAdd=RESET_PC, pc_next=RESET_PC, o_count=0, o_empty=1,
//   o_full=0, o_insValid=0; o_ins/o_insPC read 0 whenever o_empty=1. Reset overrides all inputs.
//  Regs: o_memAdd (outstanding addr), pc_next (next fetch addr), DEPTH x {ins,pc} array, rd/wr ptrs.
//  FSM IDLE: o_memReq=0. If count_next<DEPTH (or redirect): ->REQ, o_memAdd<=pc_next, pc_next+=4.
//  FSM REQ: o_memReq=1; o_memAdd held stable until i_memAck (never withdrawn or changed).
//   ack & !redirect: push {i_memIns,o_memAdd}; if count_next<DEPTH issue next req (stay REQ,
//   back-to-back, 1 ins/cycle max) else ->IDLE.
//   ack & redirect: ack data discarded; ->REQ at i_redirectPC.
//   !ack & redirect: ->DROP; pc_next<=i_redirectPC.
//  FSM DROP: o_memReq=1, old o_memAdd held; on ack: data discarded, ->REQ at pc_next.
//   Redirect in DROP: pc_next updated, stay DROP.
//  count_next = count + push - pop; pop = i_insTake & o_insValid & !i_redirect.
//  Req issued only when count_next<DEPTH: push on full impossible; push+pop same cycle keeps count.
//  i_insTake while empty: ignored. Redirect: count<=0, ptrs<=0, same-cycle take and push ignored.
//  Latency: ack at edge N -> o_insValid at N+1 (queue empty). Reset release -> o_memReq next cycle.
//  Pointers wrap mod DEPTH; pc_next+4 wraps modulo 2^64.
//  Head outputs combinational from array at rd ptr; all other outputs registered.
// TESTING
//  T1 reset release, ack every cycle, take=0 -> o_memAdd 0,4,8,12; o_full=1, o_memReq=0 after 4th ack.
//  T2 from T1 full, take 1 cycle -> o_ins=word@0, o_insPC=0, o_count 3, next req o_memAdd=16.
//  T3 req @0x8 outstanding, redirect 0x100, ack 3 cycles later -> word dropped, o_insValid=0, next o_memAdd=0x100.
//  T4 redirect 0x203 same cycle as ack and take, count 2 -> count 0, next o_memAdd=0x200.
//  T5 ack and take every cycle for 10 ins -> o_insPC 0,4..36 in order, o_count<=1, no gaps after fill.
//  T6 i_rst while REQ with 3 queued -> next cycle o_memReq=0, o_count=0; then refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the fetch-queue bus signals.
//   Memory side : mem_req/mem_add (out), mem_ack/mem_ins (in)
//   Core side   : ins_valid/ins/ins_pc (out), ins_take (in)
//   Control     : redirect/redirect_pc (in)
//   Status      : count/full/empty (out)
// modport master = the fetch queue itself, modport slave = its environment.
interface fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          mem_req;
   logic [63:0]   mem_add;
   logic          mem_ack;
   logic [31:0]   mem_ins;
   logic          ins_valid;
   logic [31:0]   ins;
   logic [63:0]   ins_pc;
   logic          ins_take;
   logic          redirect;
   logic [63:0]   redirect_pc;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   modport master (
      output mem_req, mem_add, ins_valid, ins, ins_pc, count, full, empty,
      input  mem_ack, mem_ins, ins_take, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_add, ins_valid, ins, ins_pc, count, full, empty,
      output mem_ack, mem_ins, ins_take, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage. Owns the fetch PC, issues one
// request at a time to a wait-state instruction memory (req held with a
// stable address until ack), buffers up to DEPTH {ins,pc} entries and
// hands them to the core in order. A redirect flushes the queue and
// restarts fetching at the new (word-aligned) address.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high, overrides all inputs
//   bus  - fetch_queue_if.master (memory req/ack, queue head, status)
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state, state_nxt;
   logic [63:0]   mem_add, mem_add_nxt;
   logic [63:0]   pc_next, pc_next_nxt;
   logic [31:0]   ins_q [DEPTH];
   logic [63:0]   pc_q  [DEPTH];
   logic [PW-1:0] rd, wr;
   logic [CW-1:0] count, cnt_nxt;
   logic          push, pop, valid;
   logic [63:0]   rpc;

   assign rpc   = {bus.redirect_pc[63:2], 2'b00};
   assign valid = (count != '0);
   // A redirect kills both the same-cycle pop and the same-cycle push.
   assign pop   = bus.ins_take & valid & ~bus.redirect;
   assign push  = (state == REQ) & bus.mem_ack & ~bus.redirect;
   assign cnt_nxt = count + CW'(push) - CW'(pop);

   always_comb begin
      state_nxt   = state;
      mem_add_nxt = mem_add;
      pc_next_nxt = pc_next;
      case (state)
         IDLE: begin
            if (bus.redirect) begin
               state_nxt   = REQ;
               mem_add_nxt = rpc;
               pc_next_nxt = rpc + 64'd4;
            end else if (cnt_nxt < DEPTH_C) begin
               state_nxt   = REQ;
               mem_add_nxt = pc_next;
               pc_next_nxt = pc_next + 64'd4;
            end
         end
         REQ: begin
            if (bus.mem_ack) begin
               if (bus.redirect) begin
                  mem_add_nxt = rpc;
                  pc_next_nxt = rpc + 64'd4;
               end else if (cnt_nxt < DEPTH_C) begin
                  // back-to-back issue: the only way to sustain 1 ins/cycle
                  mem_add_nxt = pc_next;
                  pc_next_nxt = pc_next + 64'd4;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (bus.redirect) begin
               // request already on the bus must complete; its data is junk
               state_nxt   = DROP;
               pc_next_nxt = rpc;
            end
         end
         DROP: begin
            if (bus.mem_ack) begin
               state_nxt = REQ;
               if (bus.redirect) begin
                  mem_add_nxt = rpc;
                  pc_next_nxt = rpc + 64'd4;
               end else begin
                  mem_add_nxt = pc_next;
                  pc_next_nxt = pc_next + 64'd4;
               end
            end else if (bus.redirect) begin
               pc_next_nxt = rpc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mem_add <= RESET_PC;
         pc_next <= RESET_PC;
         count   <= '0;
         rd      <= '0;
         wr      <= '0;
      end else begin
         state   <= state_nxt;
         mem_add <= mem_add_nxt;
         pc_next <= pc_next_nxt;
         if (bus.redirect) begin
            count <= '0;
            rd    <= '0;
            wr    <= '0;
         end else begin
            count <= cnt_nxt;
            if (push) wr <= wr + PW'(1);
            if (pop)  rd <= rd + PW'(1);
         end
      end
   end

   // Storage carries no reset; entries are only visible while count>0.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         ins_q[wr] <= bus.mem_ins;
         pc_q[wr]  <= mem_add;
      end
   end

   assign bus.mem_req   = (state != IDLE);
   assign bus.mem_add   = mem_add;
   assign bus.ins_valid = valid;
   assign bus.ins       = valid ? ins_q[rd] : 32'h0;
   assign bus.ins_pc    = valid ? pc_q[rd]  : 64'h0;
   assign bus.count     = count;
   assign bus.full      = (count == DEPTH_C);
   assign bus.empty     = ~valid;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// A per-cycle vector table covers fill-to-full and the first pop; hand
// sequences cover redirect-with-drop, redirect colliding with ack/take,
// streaming through a scoreboard, and reset in mid-fetch.
module tb_fetch_queue;
   logic clk = 1'b0;
   logic rst;

   fetch_queue_if #(.DEPTH(4)) bus ();

   fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;

   typedef struct {
      logic [31:0] ins;
      logic [63:0] pc;
   } ent_t;
   ent_t sb[$];

   typedef struct {
      logic        ack;
      logic        take;
      logic        exp_req;
      logic [63:0] exp_add;
      int          exp_count;
      logic [63:0] exp_pc;
   } vec_t;
   vec_t tbl[8];

   function automatic logic [31:0] word(input logic [63:0] a);
      return 32'hD503_0000 ^ a[31:0] ^ (a[31:0] << 12);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs; return at the following negedge.
   task automatic step(input logic ack, input logic take, input logic redir,
                       input logic [63:0] rpc);
      bus.mem_ack     = ack;
      bus.ins_take    = take;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      bus.mem_ins     = word(bus.mem_add);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 1'b0, 64'h0);
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] exp_a;
      int          pops;
      ent_t        e;

      rst = 1'b1;
      bus.mem_ack = 1'b0; bus.ins_take = 1'b0; bus.redirect = 1'b0;
      bus.redirect_pc = 64'h0; bus.mem_ins = 32'h0;
      @(negedge clk);
      do_reset();

      // reset state
      chk("rst_req",   64'(bus.mem_req),   64'd0);
      chk("rst_add",   bus.mem_add,        64'd0);
      chk("rst_count", 64'(bus.count),     64'd0);
      chk("rst_empty", 64'(bus.empty),     64'd1);
      chk("rst_full",  64'(bus.full),      64'd0);
      chk("rst_valid", 64'(bus.ins_valid), 64'd0);
      chk("rst_ins",   64'(bus.ins),       64'd0);
      chk("rst_pc",    bus.ins_pc,         64'd0);

      // T1/T2: fill to full with ack every cycle, then a single pop
      //            ack   take  req   add     cnt pc
      tbl[0] = '{1'b0, 1'b0, 1'b0, 64'd0,  0, 64'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 64'd0,  0, 64'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 64'd4,  1, 64'd0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 64'd8,  2, 64'd0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 64'd12, 3, 64'd0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 64'd12, 4, 64'd0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 64'd16, 3, 64'd4};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 64'd16, 3, 64'd4};
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_req[%0d]", i),   64'(bus.mem_req),   64'(tbl[i].exp_req));
         chk($sformatf("t1_add[%0d]", i),   bus.mem_add,        tbl[i].exp_add);
         chk($sformatf("t1_count[%0d]", i), 64'(bus.count),     64'(tbl[i].exp_count));
         chk($sformatf("t1_full[%0d]", i),  64'(bus.full),      64'(tbl[i].exp_count == 4));
         chk($sformatf("t1_empty[%0d]", i), 64'(bus.empty),     64'(tbl[i].exp_count == 0));
         chk($sformatf("t1_pc[%0d]", i),    bus.ins_pc,
             (tbl[i].exp_count != 0) ? tbl[i].exp_pc : 64'd0);
         chk($sformatf("t1_ins[%0d]", i),   64'(bus.ins),
             (tbl[i].exp_count != 0) ? 64'(word(tbl[i].exp_pc)) : 64'd0);
         step(tbl[i].ack, tbl[i].take, 1'b0, 64'h0);
      end

      // T3: redirect while req @8 outstanding; ack lands 3 cycles later
      do_reset();
      step(1'b0, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t3_add_pre",   bus.mem_add,    64'h8);
      chk("t3_count_pre", 64'(bus.count), 64'd2);
      step(1'b0, 1'b0, 1'b1, 64'h100);
      chk("t3_drop_valid", 64'(bus.ins_valid), 64'd0);
      chk("t3_drop_req",   64'(bus.mem_req),   64'd1);
      chk("t3_drop_add",   bus.mem_add,        64'h8);
      step(1'b0, 1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 1'b0, 64'h0);
      chk("t3_hold_add",   bus.mem_add,        64'h8);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t3_valid", 64'(bus.ins_valid), 64'd0);
      chk("t3_count", 64'(bus.count),     64'd0);
      chk("t3_add",   bus.mem_add,        64'h100);
      chk("t3_req",   64'(bus.mem_req),   64'd1);

      // T4: redirect to misaligned 0x203 together with ack and take
      step(1'b1, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t4_count_pre", 64'(bus.count), 64'd2);
      chk("t4_pc_pre",    bus.ins_pc,     64'h100);
      step(1'b1, 1'b1, 1'b1, 64'h203);
      chk("t4_count", 64'(bus.count),     64'd0);
      chk("t4_valid", 64'(bus.ins_valid), 64'd0);
      chk("t4_add",   bus.mem_add,        64'h200);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t4_head_pc",  bus.ins_pc,   64'h200);
      chk("t4_head_ins", 64'(bus.ins), 64'(word(64'h200)));
      chk("t4_next_add", bus.mem_add,  64'h204);

      // T5: restart at 0, stream 10 instructions with ack+take every cycle
      step(1'b1, 1'b0, 1'b1, 64'h0);
      chk("t5_count0", 64'(bus.count), 64'd0);
      sb.delete();
      exp_a = 64'h0;
      pops  = 0;
      for (int i = 0; i <= 10; i++) begin
         chk($sformatf("t5_cnt_le1[%0d]", i), 64'(bus.count <= 1), 64'd1);
         if (i >= 1) chk($sformatf("t5_nogap[%0d]", i), 64'(bus.ins_valid), 64'd1);
         if (bus.ins_valid) begin
            if (sb.size() == 0) begin
               chk($sformatf("t5_sb_underflow[%0d]", i), 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("t5_pc[%0d]", i),  bus.ins_pc,   e.pc);
               chk($sformatf("t5_ins[%0d]", i), 64'(bus.ins), 64'(e.ins));
               pops++;
            end
         end
         if (i < 10) begin
            chk($sformatf("t5_add[%0d]", i), bus.mem_add, exp_a);
            sb.push_back('{word(exp_a), exp_a});
            exp_a += 64'd4;
         end
         step(i < 10, 1'b1, 1'b0, 64'h0);
      end
      chk("t5_pops",     64'(pops),      64'd10);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);
      chk("t5_count_end", 64'(bus.count), 64'd0);

      // T6: reset mid-fetch with 3 queued, then refetch from RESET_PC
      do_reset();
      step(1'b0, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t6_count_pre", 64'(bus.count),   64'd3);
      chk("t6_req_pre",   64'(bus.mem_req), 64'd1);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0, 64'h0);
      chk("t6_req",   64'(bus.mem_req),   64'd0);
      chk("t6_count", 64'(bus.count),     64'd0);
      chk("t6_add",   bus.mem_add,        64'd0);
      chk("t6_valid", 64'(bus.ins_valid), 64'd0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 64'h0);
      chk("t6_rereq", 64'(bus.mem_req), 64'd1);
      chk("t6_readd", bus.mem_add,      64'd0);
      step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t6_head_pc", bus.ins_pc,     64'd0);
      chk("t6_count1",  64'(bus.count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
